// File: rtl/trigger_conditioner_pkg.sv
// Shared types and helpers for the trigger conditioner: FSM state encoding
// and the counter-width calculation used for the debounce and hold counters.
package trigger_conditioner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_DEB_PRESS   = 2'd1,
        ST_PRESSED     = 2'd2,
        ST_DEB_RELEASE = 2'd3
    } trig_state_e;

    // Bits needed to hold every value 0..limit without wrapping.
    function automatic int cnt_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/trig_sync.sv
// Parameterised flop-chain synchronizer for an asynchronous single-bit input.
// Every stage resets to 0; only the last stage is visible to the caller.
module trig_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the raw input one stage deeper per clock.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_i};
    end

    // Chain register with asynchronous clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {STAGES{1'b0}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/trigger_conditioner.sv
// Turns a raw, bouncy, asynchronous trigger into a debounced level plus
// single-cycle press, release and long-hold pulses in the wb_clk_i domain.
module trigger_conditioner
    import trigger_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 1024
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic en_i,
    input  logic raw_i,
    output logic btn_level_o,
    output logic press_pulse_o,
    output logic release_pulse_o,
    output logic hold_pulse_o
);

    localparam int DW = cnt_width(DEBOUNCE_CYCLES);
    localparam int HW = cnt_width(HOLD_CYCLES);
    localparam logic [DW:0]   DEB_LIMIT = (DW+1)'(DEBOUNCE_CYCLES);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);

    logic s_in;

    trig_state_e     state_q, state_d;
    logic [DW-1:0]   deb_cnt_q, deb_cnt_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic            release_q, release_d;
    logic            hold_q, hold_d;
    logic [DW:0]     deb_inc;
    logic [HW-1:0]   hold_inc;

    trig_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i (wb_clk_i),
        .rst_i (wb_rst_i),
        .d_i   (raw_i),
        .q_o   (s_in)
    );

    // Next-state, counter and pulse logic; en_i low overrides everything.
    always_comb begin
        state_d    = state_q;
        deb_cnt_d  = deb_cnt_q;
        hold_cnt_d = hold_cnt_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        hold_d     = 1'b0;
        deb_inc    = {1'b0, deb_cnt_q} + (DW+1)'(1);
        hold_inc   = hold_cnt_q + HW'(1);

        if (!en_i) begin
            state_d    = ST_IDLE;
            deb_cnt_d  = {DW{1'b0}};
            hold_cnt_d = {HW{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A single-cycle debounce accepts the press on first sight.
                    if (s_in && (DEB_LIMIT == (DW+1)'(1))) begin
                        state_d   = ST_PRESSED;
                        deb_cnt_d = {DW{1'b0}};
                        press_d   = 1'b1;
                    end else if (s_in) begin
                        state_d   = ST_DEB_PRESS;
                        deb_cnt_d = DW'(1);
                    end else begin
                        deb_cnt_d = {DW{1'b0}};
                    end
                end
                ST_DEB_PRESS: begin
                    if (!s_in) begin
                        state_d   = ST_IDLE;
                        deb_cnt_d = {DW{1'b0}};
                    end else if (deb_inc >= DEB_LIMIT) begin
                        state_d   = ST_PRESSED;
                        deb_cnt_d = {DW{1'b0}};
                        press_d   = 1'b1;
                    end else begin
                        deb_cnt_d = deb_inc[DW-1:0];
                    end
                end
                ST_PRESSED: begin
                    // Hold timing runs on the exit edge too, so a hold that
                    // matures as the release begins is still reported.
                    if (hold_cnt_q != HOLD_MAX) begin
                        hold_cnt_d = hold_inc;
                        hold_d     = (hold_inc == HOLD_MAX);
                    end else begin
                        hold_cnt_d = hold_cnt_q;
                    end
                    if (!s_in) begin
                        state_d   = ST_DEB_RELEASE;
                        deb_cnt_d = DW'(1);
                    end else begin
                        deb_cnt_d = {DW{1'b0}};
                    end
                end
                ST_DEB_RELEASE: begin
                    if (s_in) begin
                        state_d   = ST_PRESSED;
                        deb_cnt_d = {DW{1'b0}};
                    end else if (deb_inc >= DEB_LIMIT) begin
                        state_d    = ST_IDLE;
                        deb_cnt_d  = {DW{1'b0}};
                        hold_cnt_d = {HW{1'b0}};
                        release_d  = 1'b1;
                    end else begin
                        deb_cnt_d = deb_inc[DW-1:0];
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    deb_cnt_d  = {DW{1'b0}};
                    hold_cnt_d = {HW{1'b0}};
                end
            endcase
        end

        level_d = (state_d == ST_PRESSED) || (state_d == ST_DEB_RELEASE);
    end

    // State, counters and registered outputs with asynchronous reset.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= ST_IDLE;
            deb_cnt_q  <= {DW{1'b0}};
            hold_cnt_q <= {HW{1'b0}};
            level_q    <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            hold_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            deb_cnt_q  <= deb_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
            hold_q     <= hold_d;
        end
    end

    assign btn_level_o     = level_q;
    assign press_pulse_o   = press_q;
    assign release_pulse_o = release_q;
    assign hold_pulse_o    = hold_q;

endmodule

// File: tb/tb_trigger_conditioner.sv
// Directed bench for trigger_conditioner with SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4, HOLD_CYCLES=20.
module tb_trigger_conditioner;

    logic wb_clk_i;
    logic wb_rst_i;
    logic en_i;
    logic raw_i;
    logic btn_level_o;
    logic press_pulse_o;
    logic release_pulse_o;
    logic hold_pulse_o;

    int checks;
    int failures;

    typedef struct {
        logic raw;
        logic en;
        logic lvl;
        logic prs;
        logic rel;
        logic hld;
    } vec_t;

    vec_t vecs[$];

    trigger_conditioner #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (20)
    ) dut (
        .wb_clk_i        (wb_clk_i),
        .wb_rst_i        (wb_rst_i),
        .en_i            (en_i),
        .raw_i           (raw_i),
        .btn_level_o     (btn_level_o),
        .press_pulse_o   (press_pulse_o),
        .release_pulse_o (release_pulse_o),
        .hold_pulse_o    (hold_pulse_o)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check(input string name, input logic act, input logic exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic lvl, input logic p,
                             input logic r, input logic h);
        check({name, ".level"},   btn_level_o,     lvl);
        check({name, ".press"},   press_pulse_o,   p);
        check({name, ".release"}, release_pulse_o, r);
        check({name, ".hold"},    hold_pulse_o,    h);
    endtask

    task automatic add(input logic raw, input logic en, input logic lvl,
                       input logic p, input logic r, input logic h, input int n);
        vec_t v;
        v.raw = raw; v.en = en; v.lvl = lvl; v.prs = p; v.rel = r; v.hld = h;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    // Drive inputs just after an edge, then sample 1 time unit after the next edge.
    task automatic step(input logic raw, input logic en);
        raw_i = raw;
        en_i  = en;
        @(posedge wb_clk_i);
        #1;
    endtask

    // From reset release with raw_i already high: press exactly at edge 6.
    task automatic latency_after_reset(input string name);
        for (int k = 1; k <= 6; k++) begin
            step(1'b1, 1'b1);
            check_all($sformatf("%s.e%0d", name, k), (k == 6), (k == 6), 1'b0, 1'b0);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        wb_rst_i = 1'b1;
        en_i     = 1'b1;
        raw_i    = 1'b0;

        // Clean press and release.
        add(1,1,0,0,0,0,5); add(1,1,1,1,0,0,1); add(1,1,1,0,0,0,4);
        add(0,1,1,0,0,0,5); add(0,1,0,0,1,0,1); add(0,1,0,0,0,0,2);
        // Bounce, then six stable highs, then release.
        add(1,1,0,0,0,0,2); add(0,1,0,0,0,0,1); add(1,1,0,0,0,0,3);
        add(0,1,0,0,0,0,2);
        add(1,1,0,0,0,0,5); add(1,1,1,1,0,0,1);
        add(0,1,1,0,0,0,5); add(0,1,0,0,1,0,1); add(0,1,0,0,0,0,1);
        // Long hold: one hold pulse at edge 26, none afterwards.
        add(1,1,0,0,0,0,5); add(1,1,1,1,0,0,1); add(1,1,1,0,0,0,19);
        add(1,1,1,0,0,1,1); add(1,1,1,0,0,0,14);
        add(0,1,1,0,0,0,5); add(0,1,0,0,1,0,1); add(0,1,0,0,0,0,2);
        // Enable drop while pressed, re-enable with raw still high.
        add(1,1,0,0,0,0,5); add(1,1,1,1,0,0,1); add(1,1,1,0,0,0,1);
        add(1,0,0,0,0,0,2); add(1,1,0,0,0,0,3); add(1,1,1,1,0,0,1);
        add(0,1,1,0,0,0,5); add(0,1,0,0,1,0,1); add(0,1,0,0,0,0,2);

        repeat (2) @(posedge wb_clk_i);
        #1;
        check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        #2 wb_rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1);
            check_all($sformatf("idle%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].raw, vecs[i].en);
            check_all($sformatf("vec%0d", i), vecs[i].lvl, vecs[i].prs,
                      vecs[i].rel, vecs[i].hld);
        end

        // Async reset while PRESSED: outputs clear between edges.
        for (int k = 1; k <= 7; k++) step(1'b1, 1'b1);
        check("pre_rst_level", btn_level_o, 1'b1);
        #2 wb_rst_i = 1'b1;
        #1 check_all("rst_mid_pressed", 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge wb_clk_i);
        #3 wb_rst_i = 1'b0;
        latency_after_reset("lat_a");

        // Back to idle, then async reset in the middle of DEB_PRESS.
        for (int k = 1; k <= 8; k++) step(1'b0, 1'b1);
        check("idle_before_b", btn_level_o, 1'b0);
        for (int k = 1; k <= 4; k++) step(1'b1, 1'b1);
        #2 wb_rst_i = 1'b1;
        #1 check_all("rst_mid_deb", 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge wb_clk_i);
        #3 wb_rst_i = 1'b0;
        latency_after_reset("lat_b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
